// File: rtl/hp_mul_issue_queue.sv
// ---------------------------------------------------------------------------
// hp_mul_issue_queue
//
// Operand-side issue stage for the half-precision multiplier. Binary16
// operand pairs arrive on a valid/ready handshake and wait in a small
// circular FIFO. The head pair is driven straight onto the combinational
// multiplier inputs, and the returned product/flag are captured into a
// registered, back-pressurable result port. Three saturating counters
// record the exception flags of every issued result.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake; in_a/in_b binary16 operands
//   mul_a/mul_b              head operands to the multiplier (0 when empty)
//   mul_product/mul_ex_flag  multiplier response, flag encoded {UF,OF}
//   out_valid/out_ready      result handshake; out_product/out_ex_flag data
//   clr_counts               clears all counters (wins over an increment)
//   of_count/uf_count/inv_count  saturating counts of flags 01/10/11
// ---------------------------------------------------------------------------
module hp_mul_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [15:0]      mul_product,
    input  logic [1:0]       mul_ex_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_product,
    output logic [1:0]       out_ex_flag,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] of_count,
    output logic [CNT_W-1:0] uf_count,
    output logic [CNT_W-1:0] inv_count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    // Flag encodings as returned by the multiplier ({UF,OF}).
    localparam logic [1:0] FLAG_OF  = 2'b01;
    localparam logic [1:0] FLAG_UF  = 2'b10;
    localparam logic [1:0] FLAG_INV = 2'b11;

    pair_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            not_empty;
    logic            push;
    logic            issue;
    pair_t           head;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    assign not_empty = (count != '0);

    // Readiness depends only on occupancy: a pop in a full cycle does not
    // free a slot for a same-cycle push, keeping out_ready off this path.
    assign in_ready  = (count < FULL) && !rst;
    assign push      = in_valid && in_ready;

    // The result register takes a new product whenever it is empty or is
    // being drained this cycle.
    assign issue     = not_empty && (!out_valid || out_ready);

    assign head      = mem[rd_ptr];
    assign mul_a     = not_empty ? head.a : 16'h0000;
    assign mul_b     = not_empty ? head.b : 16'h0000;

    // -----------------------------------------------------------------------
    // Operand storage (no reset needed: entries are only read when counted)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b};
        end
    end

    // -----------------------------------------------------------------------
    // Pointers and occupancy
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Result register: data holds its last value once drained
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_product <= 16'h0000;
            out_ex_flag <= 2'b00;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_product <= mul_product;
            out_ex_flag <= mul_ex_flag;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Exception counters
    // -----------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr_counts) begin
            of_count  <= '0;
            uf_count  <= '0;
            inv_count <= '0;
        end else if (issue) begin
            unique case (mul_ex_flag)
                FLAG_OF:  of_count  <= sat_inc(of_count);
                FLAG_UF:  uf_count  <= sat_inc(uf_count);
                FLAG_INV: inv_count <= sat_inc(inv_count);
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_mul_issue_queue.sv
// Scoreboard bench for hp_mul_issue_queue. A stand-in multiplier answers the
// DUT's mul_a/mul_b; expected results are queued when a pair is accepted and
// the monitor compares the result port against the queue head.
module tb_hp_mul_issue_queue;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int MAX_CNT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a, in_b;
    logic [15:0]      mul_a, mul_b;
    logic [15:0]      mul_product;
    logic [1:0]       mul_ex_flag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_product;
    logic [1:0]       out_ex_flag;
    logic             clr_counts;
    logic [CNT_W-1:0] of_count, uf_count, inv_count;

    always #5 clk = ~clk;

    hp_mul_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_ex_flag(mul_ex_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_ex_flag(out_ex_flag),
        .clr_counts(clr_counts),
        .of_count(of_count), .uf_count(uf_count), .inv_count(inv_count)
    );

    // Stand-in multiplier: known binary16 cases from the multiplier's
    // characterisation, otherwise an arbitrary but deterministic mix.
    function automatic logic [17:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h4000_4200: return {2'b00, 16'h4600};
            32'h0000_3C00: return {2'b00, 16'h0000};
            32'h7C00_3C00: return {2'b11, 16'h7D55};
            32'h7800_7800: return {2'b01, 16'h3400};
            32'h0400_0400: return {2'b10, 16'h0000};
            default:       return {a[1:0] ^ b[15:14], (a ^ {b[7:0], b[15:8]}) + 16'h1357};
        endcase
    endfunction

    assign {mul_ex_flag, mul_product} = mul_ref(mul_a, mul_b);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [17:0] exp_q[$];
    int mdl_of = 0, mdl_uf = 0, mdl_inv = 0;

    always @(negedge clk) begin
        logic [17:0] r;
        if (rst) begin
            exp_q.delete();
            mdl_of = 0; mdl_uf = 0; mdl_inv = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL stale_result: got %h with no result expected", {out_ex_flag, out_product});
                end else begin
                    check("result", {14'd0, out_ex_flag, out_product}, {14'd0, exp_q[0]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                r = mul_ref(in_a, in_b);
                exp_q.push_back(r);
                case (r[17:16])
                    2'b01: if (mdl_of  < MAX_CNT) mdl_of++;
                    2'b10: if (mdl_uf  < MAX_CNT) mdl_uf++;
                    2'b11: if (mdl_inv < MAX_CNT) mdl_inv++;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit done = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !out_valid) begin done = 1; break; end
            cyc();
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_of"},  32'(of_count),  32'(mdl_of));
        check({tag, "_uf"},  32'(uf_count),  32'(mdl_uf));
        check({tag, "_inv"}, 32'(inv_count), 32'(mdl_inv));
    endtask

    task automatic latency_check(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [17:0] e;
        e = mul_ref(a, b);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b;
        @(negedge clk);
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        cyc();
        @(negedge clk);
        check({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_lat2_data"}, {14'd0, out_ex_flag, out_product}, {14'd0, e});
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sa [4];
        logic [15:0] sb [4];
        sa = '{16'h0000, 16'h7C00, 16'h7800, 16'h0400};
        sb = '{16'h3C00, 16'h3C00, 16'h7800, 16'h0400};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; clr_counts = 1'b0;
        cyc(); cyc();

        // reset state
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", {14'd0, out_ex_flag, out_product}, 32'd0);
        check("rst_mul_ab", {mul_a, mul_b}, 32'd0);
        check("rst_counts", {8'd0, of_count, uf_count, inv_count}, 32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        cyc();

        // basic
        latency_check("basic", 16'h4000, 16'h4200);
        check("basic_product", 32'(out_product), 32'h4600);
        drain();
        check("basic_counts", {8'd0, of_count, uf_count, inv_count}, 32'd0);

        // specials
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = sa[i]; in_b = sb[i];
            cyc();
        end
        drain();
        check("spec_of", 32'(of_count), 32'd1);
        check("spec_uf", 32'(uf_count), 32'd1);
        check("spec_inv", 32'(inv_count), 32'd1);

        // backpressure: 5 accepted, 6th held off
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
            @(negedge clk);
            check("bp_in_ready_hi", 32'(in_ready), 32'd1);
            cyc();
        end
        in_a = 16'($urandom); in_b = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_lo", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            cyc();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("bp_drain_valid", 32'(out_valid), 32'd1);
            if (j == 0) check("bp_ready_first_drain", 32'(in_ready), 32'd0);
            if (j == 1) check("bp_ready_rise", 32'(in_ready), 32'd1);
            cyc();
            if (j == 1) in_valid = 1'b0;
        end
        drain();
        check_counts("bp");

        // streaming
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2) check("stream_out_valid", 32'(out_valid), 32'd1);
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stream_tail_valid", 32'(out_valid), 32'd1);
            cyc();
        end
        drain();
        check_counts("stream");

        // overflow counter saturation
        out_ready = 1'b1;
        for (int i = 0; i < MAX_CNT + 4; i++) begin
            in_valid = 1'b1; in_a = 16'h7800; in_b = 16'h7800;
            cyc();
        end
        drain();
        check("sat_of", 32'(of_count), 32'(MAX_CNT));
        check_counts("sat");

        // clear in the same cycle as an OF issue
        in_valid = 1'b1; in_a = 16'h7800; in_b = 16'h7800;
        cyc();
        in_valid = 1'b0; clr_counts = 1'b1;
        @(negedge clk);
        check("clr_issue_pending", 32'(out_valid), 32'd0);
        cyc();
        clr_counts = 1'b0;
        @(negedge clk);
        check("clr_of", 32'(of_count), 32'd0);
        check("clr_uf", 32'(uf_count), 32'd0);
        check("clr_inv", 32'(inv_count), 32'd0);
        mdl_of = 0; mdl_uf = 0; mdl_inv = 0;
        cyc();
        in_valid = 1'b1; in_a = 16'h7800; in_b = 16'h7800;
        cyc();
        drain();
        check("clr_then_of", 32'(of_count), 32'd1);
        check_counts("clr");

        // reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_out_valid", 32'(out_valid), 32'd1);
        cyc();
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        cyc();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_post_out_valid", 32'(out_valid), 32'd0);
            check("mid_post_data", {14'd0, out_ex_flag, out_product}, 32'd0);
            check("mid_post_mul", {mul_a, mul_b}, 32'd0);
            check("mid_post_counts", {8'd0, of_count, uf_count, inv_count}, 32'd0);
            check("mid_post_in_ready", 32'(in_ready), 32'd1);
            cyc();
        end
        latency_check("fresh", 16'h4000, 16'h4200);
        drain();
        check_counts("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
